// File: rtl/pipe_stall_ctrl_pkg.sv
// ============================================================================
// pipe_stall_ctrl_pkg : stall encodings and FSM state types for pipe_stall_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_stall_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    // stall[0]=pc ... stall[5]=wb; wb is never frozen
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_EX   = {{2{NO_STOP}}, {4{STOP}}};
    localparam logic [5:0] STALL_MEM  = {NO_STOP, {5{STOP}}};

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_RUN  = 2'd1,
        D_DONE = 2'd2
    } div_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_ACK  = 2'd2
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_div_seq.sv
// ============================================================================
// div_seq : multi-cycle EX divide sequencer (IDLE -> RUN -> DONE)
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
)(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic flush,
    input  logic hold,
    output logic busy,
    output logic done,
    output logic ex_stall
);

    // RUN lasts DIV_CYCLES-1 cycles so done is first high DIV_CYCLES after start
    localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(DIV_CYCLES - 2);

    div_state_t      r_state;
    div_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= D_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            D_IDLE: begin
                if (start && !flush) begin
                    w_state_nxt = D_RUN;
                    w_cnt_nxt   = C_CNT_LOAD;
                end
            end
            D_RUN: begin
                if (flush)
                    w_state_nxt = D_IDLE;
                else if (r_cnt == '0)
                    w_state_nxt = D_DONE;
                else
                    w_cnt_nxt = r_cnt - CW'(1);
            end
            D_DONE: begin
                // leave only as the divide instruction leaves EX
                if (flush || !hold)
                    w_state_nxt = D_IDLE;
            end
            default: w_state_nxt = D_IDLE;
        endcase
    end

    assign busy     = (r_state == D_RUN);
    assign ex_stall = (r_state == D_RUN);
    assign done     = (r_state == D_DONE);

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// pipe_stall_ctrl : central stall sequencer for the 6-stage pipeline
// Optional per-source cycle counters: define STALL_PERF_CNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_stallreq,
    input  logic        ex_div_start,
    input  logic        ex_flush,
    input  logic        mem_req,
    input  logic        bus_ack,
    output logic [5:0]  stall,
    output logic        div_busy,
    output logic        div_done,
    output logic        bus_req,
    output logic        mem_timeout_err,
    output logic [31:0] perf_id_cyc,
    output logic [31:0] perf_ex_cyc,
    output logic [31:0] perf_mem_cyc
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] C_TLAST = TW'(MEM_TIMEOUT - 1);

    logic          w_rst;
    logic          w_ex_stall;
    logic          w_mem_stall;
    mem_state_t    r_mstate;
    mem_state_t    w_mstate_nxt;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tcnt_nxt;
    logic          w_err_set;
    logic          r_timeout_err;

    assign w_rst = (resetn == RST_ENABLE);

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk      (clk),
        .rst      (w_rst),
        .start    (ex_div_start),
        .flush    (ex_flush),
        .hold     (stall[3]),
        .busy     (div_busy),
        .done     (div_done),
        .ex_stall (w_ex_stall)
    );

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_mstate      <= M_IDLE;
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mstate <= w_mstate_nxt;
            r_tcnt   <= w_tcnt_nxt;
            if (w_err_set)
                r_timeout_err <= 1'b1;
        end
    end

    always_comb begin
        w_mstate_nxt = r_mstate;
        w_tcnt_nxt   = r_tcnt;
        w_err_set    = 1'b0;
        case (r_mstate)
            M_IDLE: begin
                if (mem_req) begin
                    w_mstate_nxt = M_WAIT;
                    w_tcnt_nxt   = '0;
                end
            end
            M_WAIT: begin
                // an ack on the final wait cycle takes precedence over the timeout
                if (bus_ack) begin
                    w_mstate_nxt = M_ACK;
                end else if (r_tcnt == C_TLAST) begin
                    w_mstate_nxt = M_ACK;
                    w_err_set    = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            M_ACK:   w_mstate_nxt = M_IDLE;
            default: w_mstate_nxt = M_IDLE;
        endcase
    end

    assign w_mem_stall     = (r_mstate == M_WAIT);
    assign bus_req         = (r_mstate == M_WAIT);
    assign mem_timeout_err = r_timeout_err;

    always_comb begin
        stall = STALL_NONE;
        if (w_mem_stall)
            stall = STALL_MEM;
        else if (w_ex_stall)
            stall = STALL_EX;
        else if (id_stallreq)
            stall = STALL_ID;
    end

`ifdef STALL_PERF_CNT_EN
    logic        w_win_id;
    logic        w_win_ex;
    logic [31:0] r_perf_id;
    logic [31:0] r_perf_ex;
    logic [31:0] r_perf_mem;

    assign w_win_ex = !w_mem_stall && w_ex_stall;
    assign w_win_id = !w_mem_stall && !w_ex_stall && id_stallreq;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_perf_id  <= '0;
            r_perf_ex  <= '0;
            r_perf_mem <= '0;
        end else begin
            if (w_win_id && (r_perf_id != '1))
                r_perf_id <= r_perf_id + 32'd1;
            if (w_win_ex && (r_perf_ex != '1))
                r_perf_ex <= r_perf_ex + 32'd1;
            if (w_mem_stall && (r_perf_mem != '1))
                r_perf_mem <= r_perf_mem + 32'd1;
        end
    end

    assign perf_id_cyc  = r_perf_id;
    assign perf_ex_cyc  = r_perf_ex;
    assign perf_mem_cyc = r_perf_mem;
`else
    assign perf_id_cyc  = 32'd0;
    assign perf_ex_cyc  = 32'd0;
    assign perf_mem_cyc = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// tb_pipe_stall_ctrl : scoreboard bench; u_a (DIV 32, timeout 255), u_b (DIV 4, timeout 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

    logic        clk;
    logic        resetn;
    logic        id_stallreq;
    logic        ex_div_start;
    logic        ex_flush;
    logic        mem_req;
    logic        bus_ack;

    logic [5:0]  a_stall, b_stall;
    logic        a_busy, a_done, a_breq, a_err;
    logic        b_busy, b_done, b_breq, b_err;
    logic [31:0] a_pid, a_pex, a_pmem, b_pid, b_pex, b_pmem;

    typedef struct packed {
        logic       sel;
        logic [5:0] stall;
        logic       busy;
        logic       done;
        logic       breq;
        logic       err;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    pipe_stall_ctrl #(.DIV_CYCLES(32), .MEM_TIMEOUT(255)) u_a (
        .clk (clk), .resetn (resetn), .id_stallreq (id_stallreq),
        .ex_div_start (ex_div_start), .ex_flush (ex_flush),
        .mem_req (mem_req), .bus_ack (bus_ack),
        .stall (a_stall), .div_busy (a_busy), .div_done (a_done),
        .bus_req (a_breq), .mem_timeout_err (a_err),
        .perf_id_cyc (a_pid), .perf_ex_cyc (a_pex), .perf_mem_cyc (a_pmem)
    );

    pipe_stall_ctrl #(.DIV_CYCLES(4), .MEM_TIMEOUT(4)) u_b (
        .clk (clk), .resetn (resetn), .id_stallreq (id_stallreq),
        .ex_div_start (ex_div_start), .ex_flush (ex_flush),
        .mem_req (mem_req), .bus_ack (bus_ack),
        .stall (b_stall), .div_busy (b_busy), .div_done (b_done),
        .bus_req (b_breq), .mem_timeout_err (b_err),
        .perf_id_cyc (b_pid), .perf_ex_cyc (b_pex), .perf_mem_cyc (b_pmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%b required=%b at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = sb_name.pop_front();
            if (e.sel == 1'b0) begin
                chk(nm, "stall", a_stall, e.stall);
                chk(nm, "div_busy", {5'd0, a_busy}, {5'd0, e.busy});
                chk(nm, "div_done", {5'd0, a_done}, {5'd0, e.done});
                chk(nm, "bus_req", {5'd0, a_breq}, {5'd0, e.breq});
                chk(nm, "timeout_err", {5'd0, a_err}, {5'd0, e.err});
            end else begin
                chk(nm, "stall", b_stall, e.stall);
                chk(nm, "div_busy", {5'd0, b_busy}, {5'd0, e.busy});
                chk(nm, "div_done", {5'd0, b_done}, {5'd0, e.done});
                chk(nm, "bus_req", {5'd0, b_breq}, {5'd0, e.breq});
                chk(nm, "timeout_err", {5'd0, b_err}, {5'd0, e.err});
            end
        end
    end

    task automatic expect_out(input logic sel, input string nm, input logic [5:0] st,
                              input logic bz, input logic dn, input logic br, input logic er);
        exp_t e;
        e.sel = sel; e.stall = st; e.busy = bz; e.done = dn; e.breq = br; e.err = er;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        id_stallreq = 1'b0; ex_div_start = 1'b0; ex_flush = 1'b0;
        mem_req = 1'b0; bus_ack = 1'b0;
        tick();
        resetn = 1'b0;
    endtask

    initial begin
        resetn = 1'b1;
        id_stallreq = 1'b0; ex_div_start = 1'b0; ex_flush = 1'b0;
        mem_req = 1'b0; bus_ack = 1'b0;
        tick(); tick();

        // reset state of both instances
        expect_out(0, "reset_a", 6'b000000, 0, 0, 0, 0); tick();
        expect_out(1, "reset_b", 6'b000000, 0, 0, 0, 0); tick();
        resetn = 1'b0;

        // single-cycle load-use request
        do_reset();
        id_stallreq = 1'b1; expect_out(0, "id_one", 6'b000111, 0, 0, 0, 0); tick();
        id_stallreq = 1'b0; expect_out(0, "id_clear", 6'b000000, 0, 0, 0, 0); tick();

        // full 32-cycle divide
        do_reset();
        ex_div_start = 1'b1; expect_out(0, "div_c0", 6'b000000, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 31; k++) begin
            expect_out(0, "div_run", 6'b001111, 1, 0, 0, 0); tick();
        end
        ex_div_start = 1'b0; expect_out(0, "div_done", 6'b000000, 0, 1, 0, 0); tick();
        expect_out(0, "div_idle", 6'b000000, 0, 0, 0, 0); tick();

        // reset at cycle 10 of a divide
        do_reset();
        ex_div_start = 1'b1; expect_out(0, "rst_c0", 6'b000000, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 9; k++) begin
            expect_out(0, "rst_run", 6'b001111, 1, 0, 0, 0); tick();
        end
        resetn = 1'b1; expect_out(0, "rst_c10", 6'b001111, 1, 0, 0, 0); tick();
        resetn = 1'b0; ex_div_start = 1'b0;
        expect_out(0, "rst_after", 6'b000000, 0, 0, 0, 0); tick();
        expect_out(0, "rst_idle", 6'b000000, 0, 0, 0, 0); tick();

        // flush cancels a running divide
        do_reset();
        ex_div_start = 1'b1; expect_out(0, "fl_c0", 6'b000000, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin ex_flush = 1'b1; ex_div_start = 1'b0; end
            expect_out(0, "fl_run", 6'b001111, 1, 0, 0, 0); tick();
        end
        ex_flush = 1'b0; expect_out(0, "fl_idle", 6'b000000, 0, 0, 0, 0); tick();

        // MEM access acked after 5 wait cycles, then a stray ack in idle
        do_reset();
        mem_req = 1'b1; expect_out(0, "mem_c0", 6'b000000, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) bus_ack = 1'b1;
            expect_out(0, "mem_wait", 6'b011111, 0, 0, 1, 0); tick();
        end
        bus_ack = 1'b0; mem_req = 1'b0;
        expect_out(0, "mem_ack", 6'b000000, 0, 0, 0, 0); tick();
        bus_ack = 1'b1; expect_out(0, "mem_idle", 6'b000000, 0, 0, 0, 0); tick();
        bus_ack = 1'b0; expect_out(0, "mem_stray", 6'b000000, 0, 0, 0, 0); tick();

        // timeout after 4 wait cycles; error is sticky across a good access
        do_reset();
        mem_req = 1'b1; expect_out(1, "to_c0", 6'b000000, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 4; k++) begin
            expect_out(1, "to_wait", 6'b011111, 0, 0, 1, 0); tick();
        end
        mem_req = 1'b0; expect_out(1, "to_ack", 6'b000000, 0, 0, 0, 1); tick();
        expect_out(1, "to_idle", 6'b000000, 0, 0, 0, 1); tick();
        mem_req = 1'b1; expect_out(1, "to_c7", 6'b000000, 0, 0, 0, 1); tick();
        for (int k = 1; k <= 2; k++) begin
            if (k == 2) bus_ack = 1'b1;
            expect_out(1, "to_wait2", 6'b011111, 0, 0, 1, 1); tick();
        end
        bus_ack = 1'b0; mem_req = 1'b0;
        expect_out(1, "to_ack2", 6'b000000, 0, 0, 0, 1); tick();
        expect_out(1, "to_sticky", 6'b000000, 0, 0, 0, 1); tick();

        // divide completes during a 10-cycle MEM wait
        do_reset();
        ex_div_start = 1'b1; expect_out(0, "ov_c0", 6'b000000, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 25; k++) begin
            if (k == 25) mem_req = 1'b1;
            expect_out(0, "ov_run", 6'b001111, 1, 0, 0, 0); tick();
        end
        for (int k = 26; k <= 35; k++) begin
            if (k == 35) bus_ack = 1'b1;
            expect_out(0, "ov_wait", 6'b011111, (k < 32), (k >= 32), 1, 0); tick();
        end
        bus_ack = 1'b0; mem_req = 1'b0; ex_div_start = 1'b0;
        expect_out(0, "ov_ack", 6'b000000, 0, 1, 0, 0); tick();
        expect_out(0, "ov_idle", 6'b000000, 0, 0, 0, 0); tick();

        // ack on the same cycle as the timeout
        do_reset();
        mem_req = 1'b1; expect_out(1, "tie_c0", 6'b000000, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) bus_ack = 1'b1;
            expect_out(1, "tie_wait", 6'b011111, 0, 0, 1, 0); tick();
        end
        bus_ack = 1'b0; mem_req = 1'b0;
        expect_out(1, "tie_ack", 6'b000000, 0, 0, 0, 0); tick();
        expect_out(1, "tie_idle", 6'b000000, 0, 0, 0, 0); tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
